counter_sequencer: RTL and testbench
====================================

Name: counter_sequencer

Overview:
- Control FSM that sequences the PWM/timer main counter.
- Arms the counter from the ctrl register and drives its counter_en/sw_rst.
- Holds shadow copies of period/duty that update only at a period boundary (glitch-free reprogramming).
- Detects one-shot completion and raises a sticky interrupt.
- Sits between the register file and main_counter/PWM/timer cores, clocked by the bus clock, with the clock divider's tick as enable.

Parameters:
- WIDTH, 16, width of period/duty/counter values.

Ports:
- i_wb_clk  input  1  system (bus) clock.
- i_wb_rst_n  input  1  asynchronous active-low reset.
- tick  input  1  one-i_wb_clk-cycle pulse from clk_divider; main counter advances only on tick.
- ctrl_en  input  1  ctrl[2], counter enable request.
- mode  input  1  ctrl[1]: 1 = PWM, 0 = timer.
- timer_mode  input  1  ctrl[3]: 1 = continuous, 0 = one-shot.
- irq_clr  input  1  single-cycle pulse, clears irq.
- reg_wr_stb  input  1  single-cycle pulse, period_reg or duty_reg written.
- period_reg  input  WIDTH  programmed period.
- duty_reg  input  WIDTH  programmed duty.
- counter  input  WIDTH  current main counter value.
- counter_en  output  1  enable to main_counter.
- sw_rst  output  1  sync clear to main_counter.
- period_act  output  WIDTH  active (shadow) period driven to main_counter/cores.
- duty_act  output  WIDTH  active (shadow) duty.
- irq  output  1  sticky interrupt.
- done  output  1  one-shot finished.
- cfg_err  output  1  enable requested with period_reg == 0.
- state  output  2  FSM state for debug: IDLE=0, ARM=1, RUN=2, DONE=3.

Behaviour:
- Reset (async, i_wb_rst_n=0): state=IDLE, counter_en=0, sw_rst=1, period_act=0, duty_act=0, irq=0, done=0, cfg_err=0, update pending flag=0. All registered; no combinational path input->output.
- IDLE:
  - Outputs: sw_rst=1, counter_en=0, done=0.
  - If ctrl_en=1 and period_reg!=0: go to ARM next cycle and latch period_reg, duty_reg, mode and timer_mode into shadows.
  - If ctrl_en=1 and period_reg==0: stay in IDLE with cfg_err=1. cfg_err=0 otherwise.
- ARM: one cycle, sw_rst=1, counter_en=0, then go to RUN unconditionally.
- RUN:
  - Outputs: sw_rst=0, counter_en=1.
  - last = period_act-1 if latched mode=PWM, else period_act (matches main_counter: PWM counts 0..P-1, timer 0..P).
  - wrap = tick && counter==last.
- reg_wr_stb in RUN: sets the pending flag. New register values are NOT applied immediately.
- On wrap:
  - If pending: load period_reg/duty_reg into shadows and clear pending.
  - If timer mode: irq<=1.
  - If timer one-shot: go to DONE.
  - PWM and continuous timer remain in RUN.
- wrap and reg_wr_stb in the same cycle: shadows load the current register values and pending ends at 0.
- DONE:
  - Outputs: counter_en=0, sw_rst=1, done=1.
  - Stays in DONE until ctrl_en=0, then goes to IDLE.
- ctrl_en=0 in ARM/RUN/DONE: go to IDLE next cycle (sw_rst asserts, so the counter clears). Pending is cleared. irq is unaffected.
- Mode changes in RUN are ignored; they take effect only on the next IDLE->ARM transition.
- irq:
  - Set on wrap (timer mode), cleared by irq_clr.
  - Set and irq_clr in the same cycle: set wins.
  - PWM mode never sets irq.
- Shadow loads in RUN happen only on wrap. period_act never changes mid-period.
- Reset mid-RUN: returns to reset values immediately (async).

Test Plan:
- Reset:
  - Stimulus: assert i_wb_rst_n=0 mid-RUN.
  - Required: state=0, counter_en=0, sw_rst=1, irq=0, period_act=0 in the same cycle; holds after release until ctrl_en.
- PWM arm:
  - Stimulus: period_reg=4, duty_reg=2, mode=1, ctrl_en=1, tick every 4 clocks.
  - Required: IDLE->ARM->RUN over 2 cycles; period_act=4; wrap at counter=3; irq stays 0 over 3 periods.
- Timer one-shot:
  - Stimulus: period_reg=4, mode=0, timer_mode=0.
  - Required: wrap at counter=4; irq=1 and state=DONE next cycle; counter_en=0, done=1.
  - Then ctrl_en=0: state returns to IDLE and done clears.
- Shadow update:
  - Stimulus: in PWM RUN with period 10, write period_reg=6 plus reg_wr_stb at counter=3.
  - Required: period_act stays 10 until the wrap at counter=9, then becomes 6; next wrap at counter=5.
- Continuous timer, irq priority:
  - Stimulus: period 4, timer_mode=1; irq_clr asserted in the same cycle as a wrap.
  - Required: irq remains 1. A later irq_clr alone gives irq=0; the counter keeps wrapping.
- Error and abort:
  - Stimulus: ctrl_en=1 with period_reg=0.
  - Required: cfg_err=1, state stays 0.
  - Then period_reg=8, and drop ctrl_en at counter=5 in RUN: next cycle state=0, sw_rst=1, counter_en=0.

Source files
------------

// File: rtl/counter_sequencer.sv
// counter_sequencer: arms and sequences the PWM/timer main counter.
// Shadow copies of period/duty are updated only at a period boundary,
// so reprogramming never glitches a running period. It also detects
// one-shot completion and raises a sticky interrupt.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | counter held in clear; waits for ctrl_en with period != 0
//   ARM   | one-cycle settle after the shadows load; counter still clear
//   RUN   | counter enabled; shadows reload only on wrap
//   DONE  | one-shot timer finished; waits for ctrl_en to drop
module counter_sequencer #(
  parameter int WIDTH = 16
) (
  input  logic             i_wb_clk,
  input  logic             i_wb_rst_n,
  input  logic             tick,
  input  logic             ctrl_en,
  input  logic             mode,
  input  logic             timer_mode,
  input  logic             irq_clr,
  input  logic             reg_wr_stb,
  input  logic [WIDTH-1:0] period_reg,
  input  logic [WIDTH-1:0] duty_reg,
  input  logic [WIDTH-1:0] counter,
  output logic             counter_en,
  output logic             sw_rst,
  output logic [WIDTH-1:0] period_act,
  output logic [WIDTH-1:0] duty_act,
  output logic             irq,
  output logic             done,
  output logic             cfg_err,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] period_act_q, period_act_d;
  logic [WIDTH-1:0] duty_act_q, duty_act_d;
  logic             mode_q, mode_d;       // latched ctrl mode: 1 = PWM
  logic             tmode_q, tmode_d;     // latched timer mode: 1 = continuous
  logic             pending_q, pending_d; // register write awaiting the next wrap
  logic             irq_q, irq_d;
  logic             cfg_err_q, cfg_err_d;

  logic [WIDTH-1:0] last;
  logic             wrap;

  // Terminal count of the main counter: PWM counts 0..P-1, timer 0..P.
  always_comb begin
    last = mode_q ? (period_act_q - WIDTH'(1)) : period_act_q;
    wrap = tick && (counter == last);
  end

  // Next-state, shadow and interrupt logic.
  always_comb begin
    state_d      = state_q;
    period_act_d = period_act_q;
    duty_act_d   = duty_act_q;
    mode_d       = mode_q;
    tmode_d      = tmode_q;
    pending_d    = pending_q;
    irq_d        = irq_q;
    cfg_err_d    = 1'b0;

    if (irq_clr) begin
      irq_d = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        pending_d = 1'b0;
        if (ctrl_en) begin
          if (period_reg != '0) begin
            state_d      = ARM;
            period_act_d = period_reg;
            duty_act_d   = duty_reg;
            mode_d       = mode;
            tmode_d      = timer_mode;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end
      ARM: begin
        state_d = ctrl_en ? RUN : IDLE;
      end
      RUN: begin
        if (!ctrl_en) begin
          state_d   = IDLE;
          pending_d = 1'b0;
        end else if (wrap) begin
          // A write landing on the wrap cycle is picked up right away.
          if (pending_q || reg_wr_stb) begin
            period_act_d = period_reg;
            duty_act_d   = duty_reg;
          end
          pending_d = 1'b0;
          if (!mode_q) begin
            irq_d = 1'b1;
            if (!tmode_q) begin
              state_d = DONE;
            end
          end
        end else if (reg_wr_stb) begin
          pending_d = 1'b1;
        end
      end
      DONE: begin
        if (!ctrl_en) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and shadow registers.
  always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
    if (!i_wb_rst_n) begin
      state_q      <= IDLE;
      period_act_q <= '0;
      duty_act_q   <= '0;
      mode_q       <= 1'b0;
      tmode_q      <= 1'b0;
      pending_q    <= 1'b0;
      irq_q        <= 1'b0;
      cfg_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      period_act_q <= period_act_d;
      duty_act_q   <= duty_act_d;
      mode_q       <= mode_d;
      tmode_q      <= tmode_d;
      pending_q    <= pending_d;
      irq_q        <= irq_d;
      cfg_err_q    <= cfg_err_d;
    end
  end

  // Counter controls decode straight from the registered state.
  assign counter_en = (state_q == RUN);
  assign sw_rst     = (state_q != RUN);
  assign done       = (state_q == DONE);
  assign period_act = period_act_q;
  assign duty_act   = duty_act_q;
  assign irq        = irq_q;
  assign cfg_err    = cfg_err_q;
  assign state      = state_q;

endmodule

// File: tb/tb_counter_sequencer.sv
// Directed bench for counter_sequencer: a vector table walks PWM, shadow
// update, one-shot, continuous timer and error/abort sequences; an async
// reset in the middle of RUN is exercised by hand afterwards.
module tb_counter_sequencer;

  localparam int WIDTH = 16;

  logic             clk;
  logic             rst_n;
  logic             tick, ctrl_en, mode, timer_mode, irq_clr, reg_wr_stb;
  logic [WIDTH-1:0] period_reg, duty_reg, counter;
  logic             counter_en, sw_rst, irq, done, cfg_err;
  logic [WIDTH-1:0] period_act, duty_act;
  logic [1:0]       state;

  int checks = 0;
  int errors = 0;

  counter_sequencer #(.WIDTH(WIDTH)) dut (
    .i_wb_clk   (clk),
    .i_wb_rst_n (rst_n),
    .tick       (tick),
    .ctrl_en    (ctrl_en),
    .mode       (mode),
    .timer_mode (timer_mode),
    .irq_clr    (irq_clr),
    .reg_wr_stb (reg_wr_stb),
    .period_reg (period_reg),
    .duty_reg   (duty_reg),
    .counter    (counter),
    .counter_en (counter_en),
    .sw_rst     (sw_rst),
    .period_act (period_act),
    .duty_act   (duty_act),
    .irq        (irq),
    .done       (done),
    .cfg_err    (cfg_err),
    .state      (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       en, md, tm, clr, wr, tk;
    int         per, du, cnt;
    logic [1:0] st;
    logic       irq, cfg;
    int         pa, da;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic en, input logic md, input logic tm,
                     input logic clr, input logic wr, input logic tk,
                     input int per, input int du, input int cnt,
                     input logic [1:0] st, input logic ei, input logic ec,
                     input int pa, input int da);
    vec_t v;
    v.en = en; v.md = md; v.tm = tm; v.clr = clr; v.wr = wr; v.tk = tk;
    v.per = per; v.du = du; v.cnt = cnt;
    v.st = st; v.irq = ei; v.cfg = ec; v.pa = pa; v.da = da;
    vecs.push_back(v);
  endtask

  task automatic cmp(input string name, input int idx, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s (step %0d): got %0d, expected %0d", name, idx, act, exp);
    end
  endtask

  task automatic check_all(input int idx, input logic [1:0] st, input logic ei,
                           input logic ec, input int pa, input int da);
    cmp("state", idx, int'(state), int'(st));
    cmp("counter_en", idx, int'(counter_en), int'(st == 2'd2));
    cmp("sw_rst", idx, int'(sw_rst), int'(st != 2'd2));
    cmp("done", idx, int'(done), int'(st == 2'd3));
    cmp("irq", idx, int'(irq), int'(ei));
    cmp("cfg_err", idx, int'(cfg_err), int'(ec));
    cmp("period_act", idx, int'(period_act), pa);
    cmp("duty_act", idx, int'(duty_act), da);
  endtask

  task automatic drive(input logic en, input logic md, input logic tm,
                       input logic clr, input logic wr, input logic tk,
                       input int per, input int du, input int cnt);
    ctrl_en = en; mode = md; timer_mode = tm; irq_clr = clr; reg_wr_stb = wr;
    tick = tk; period_reg = WIDTH'(per); duty_reg = WIDTH'(du); counter = WIDTH'(cnt);
  endtask

  initial begin
    // en md tm clr wr tk per du cnt | st irq cfg pa da
    // config error, then clean
    add(1,0,0,0,0,0, 0,0,0,  2'd0,0,1, 0,0);
    add(0,0,0,0,0,0, 0,0,0,  2'd0,0,0, 0,0);
    // PWM arm, period 4, wraps at 3, no irq
    add(1,1,0,0,0,0, 4,2,0,  2'd1,0,0, 4,2);
    add(1,1,0,0,0,0, 4,2,0,  2'd2,0,0, 4,2);
    add(1,1,0,0,0,1, 4,2,0,  2'd2,0,0, 4,2);
    add(1,1,0,0,0,0, 4,2,3,  2'd2,0,0, 4,2);
    add(1,1,0,0,0,1, 4,2,3,  2'd2,0,0, 4,2);
    add(1,1,0,0,0,1, 4,2,3,  2'd2,0,0, 4,2);
    add(0,1,0,0,0,0, 4,2,0,  2'd0,0,0, 4,2);
    // shadow update: period 10, write 6 at counter 3
    add(1,1,0,0,0,0, 10,5,0, 2'd1,0,0, 10,5);
    add(1,1,0,0,0,0, 10,5,0, 2'd2,0,0, 10,5);
    add(1,1,0,0,1,0, 6,3,3,  2'd2,0,0, 10,5);
    add(1,1,0,0,0,1, 6,3,3,  2'd2,0,0, 10,5);
    add(1,1,0,0,0,0, 6,3,9,  2'd2,0,0, 10,5);
    add(1,1,0,0,0,1, 6,3,9,  2'd2,0,0, 6,3);
    add(1,1,0,0,0,1, 7,3,5,  2'd2,0,0, 6,3);   // wrap at 5, pending already cleared
    add(1,1,0,0,1,1, 7,1,5,  2'd2,0,0, 7,1);   // write on the wrap cycle
    add(1,1,0,0,0,1, 8,1,6,  2'd2,0,0, 7,1);   // wrap, nothing pending
    add(1,0,0,0,0,1, 8,1,7,  2'd2,0,0, 7,1);   // mode input change ignored
    add(0,0,0,0,0,0, 8,1,0,  2'd0,0,0, 7,1);
    // one-shot timer, period 4
    add(1,0,0,0,0,0, 4,0,0,  2'd1,0,0, 4,0);
    add(1,0,0,0,0,0, 4,0,0,  2'd2,0,0, 4,0);
    add(1,0,0,0,0,1, 4,0,3,  2'd2,0,0, 4,0);
    add(1,0,0,0,0,0, 4,0,4,  2'd2,0,0, 4,0);
    add(1,0,0,0,0,1, 4,0,4,  2'd3,1,0, 4,0);
    add(1,0,0,0,0,1, 4,0,0,  2'd3,1,0, 4,0);
    add(1,0,0,1,0,0, 4,0,0,  2'd3,0,0, 4,0);
    add(0,0,0,0,0,0, 4,0,0,  2'd0,0,0, 4,0);
    // continuous timer, irq set beats clear
    add(1,0,1,0,0,0, 4,0,0,  2'd1,0,0, 4,0);
    add(1,0,1,0,0,0, 4,0,0,  2'd2,0,0, 4,0);
    add(1,0,1,0,0,1, 4,0,4,  2'd2,1,0, 4,0);
    add(1,0,1,1,0,1, 4,0,4,  2'd2,1,0, 4,0);
    add(1,0,1,1,0,1, 4,0,2,  2'd2,0,0, 4,0);
    add(1,0,1,0,0,1, 4,0,4,  2'd2,1,0, 4,0);
    add(1,0,1,1,0,0, 4,0,4,  2'd2,0,0, 4,0);
    // error then abort at counter 5
    add(0,0,1,0,0,0, 4,0,0,  2'd0,0,0, 4,0);
    add(1,0,1,0,0,0, 0,0,0,  2'd0,0,1, 4,0);
    add(1,0,1,0,0,0, 8,0,0,  2'd1,0,0, 8,0);
    add(1,0,1,0,0,0, 8,0,0,  2'd2,0,0, 8,0);
    add(0,0,1,0,0,1, 8,0,5,  2'd0,0,0, 8,0);

    rst_n = 1'b0;
    drive(0,0,0,0,0,0, 0,0,0);
    #1;
    check_all(-1, 2'd0, 1'b0, 1'b0, 0, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_all(0, 2'd0, 1'b0, 1'b0, 0, 0);

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].en, vecs[i].md, vecs[i].tm, vecs[i].clr, vecs[i].wr,
            vecs[i].tk, vecs[i].per, vecs[i].du, vecs[i].cnt);
      @(posedge clk); #1;
      check_all(i + 1, vecs[i].st, vecs[i].irq, vecs[i].cfg, vecs[i].pa, vecs[i].da);
    end

    // async reset mid-RUN with irq already set
    @(negedge clk); drive(1,0,1,0,0,0, 4,3,0);
    @(posedge clk); #1; cmp("rst_seq arm", 100, int'(state), 1);
    @(negedge clk);
    @(posedge clk); #1; cmp("rst_seq run", 101, int'(state), 2);
    @(negedge clk); drive(1,0,1,0,0,1, 4,3,4);
    @(posedge clk); #1; cmp("rst_seq irq", 102, int'(irq), 1);
    @(negedge clk); drive(1,0,1,0,0,0, 4,3,1);
    #2 rst_n = 1'b0;
    #1;
    check_all(103, 2'd0, 1'b0, 1'b0, 0, 0);
    @(negedge clk); drive(0,0,1,0,0,0, 4,3,0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_all(104, 2'd0, 1'b0, 1'b0, 0, 0);
    @(negedge clk); drive(1,1,0,0,0,0, 5,2,0);
    @(posedge clk); #1;
    check_all(105, 2'd1, 1'b0, 1'b0, 5, 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
